// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// The master side drives the request and operands. The slave side returns status and the result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: a single full-adder cell processes one operand bit per clock, LSB first.
// The carry-out of each bit is registered and fed back as the carry-in of the next bit.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; sum/cout hold the last completed result
// RUN   | one bit per clock through the full adder; start is ignored
// DONE  | one-cycle result-valid pulse; start here chains the next add

module fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic c_o
);
    assign sum_o = a_i ^ b_i ^ c_i;
    assign c_o   = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Only the upper WIDTH-1 bits of the partial-sum shifter are kept.
    // The final sum bit comes straight from the adder on the last edge.
    logic [WIDTH-2:0] s_q, s_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    count_q, count_d;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] shifted;

    fa u_fa (
        .a_i   (a_q[0]),
        .b_i   (b_q[0]),
        .c_i   (carry_q),
        .sum_o (fa_sum),
        .c_o   (fa_cout)
    );

    assign shifted = {fa_sum, s_q};

    // Next-state and datapath decode
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        count_d = count_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    count_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                s_d     = shifted[WIDTH-1:1];
                carry_d = fa_cout;
                count_d = count_q + 1'b1;
                if (count_q == LAST_BIT) begin
                    state_d = S_DONE;
                    sum_d   = shifted;
                    cout_d  = fa_cout;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any add in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            count_q <= count_d;
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH=8 and WIDTH=32.
// A cycle-indexed reference model predicts busy, done, sum and cout after every clock.
// A few literal expectations pin the model to known results.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8))  if8 ();
    serial_adder_if #(.WIDTH(32)) if32 ();

    serial_adder #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8.slave)
    );

    serial_adder #(.WIDTH(32)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (if32.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: per DUT, the edge on which the current add was accepted and its full result
    int          m_e0   [2];
    bit          m_act  [2];
    bit          m_busy [2];
    bit          m_done [2];
    logic [63:0] m_pend [2];
    logic [63:0] m_res  [2];

    function automatic int wof(int k);
        return (k == 0) ? 8 : 32;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_e0[k]   = 0;
            m_act[k]  = 1'b0;
            m_busy[k] = 1'b0;
            m_done[k] = 1'b0;
            m_pend[k] = '0;
            m_res[k]  = '0;
        end
    endtask

    // One clock edge: a start is accepted only when no add is running.
    // The result appears exactly WIDTH edges after acceptance.
    task automatic model_edge(int k, bit st, logic [31:0] a, logic [31:0] b, bit c);
        if (st && !m_busy[k]) begin
            m_e0[k]   = cyc;
            m_pend[k] = 64'(a) + 64'(b) + 64'(c);
            m_act[k]  = 1'b1;
        end
        m_busy[k] = m_act[k] && (cyc < m_e0[k] + wof(k));
        m_done[k] = m_act[k] && (cyc == m_e0[k] + wof(k));
        if (m_done[k]) m_res[k] = m_pend[k];
    endtask

    task automatic compare_all();
        chk("busy8",  64'(if8.busy),  64'(m_busy[0]));
        chk("done8",  64'(if8.done),  64'(m_done[0]));
        chk("sum8",   64'(if8.sum),   m_res[0] & 64'hFF);
        chk("cout8",  64'(if8.cout),  (m_res[0] >> 8) & 64'd1);
        chk("busy32", 64'(if32.busy), 64'(m_busy[1]));
        chk("done32", 64'(if32.done), 64'(m_done[1]));
        chk("sum32",  64'(if32.sum),  m_res[1] & 64'hFFFF_FFFF);
        chk("cout32", 64'(if32.cout), (m_res[1] >> 32) & 64'd1);
    endtask

    task automatic tick(int k, bit st, logic [31:0] a, logic [31:0] b, bit c);
        logic [31:0] ma, mb;
        ma = (k == 0) ? (a & 32'hFF) : a;
        mb = (k == 0) ? (b & 32'hFF) : b;
        if (k == 0) begin
            if8.start  = st;
            if8.a      = ma[7:0];
            if8.b      = mb[7:0];
            if8.cin    = c;
            if32.start = 1'b0;
        end else begin
            if32.start = st;
            if32.a     = ma;
            if32.b     = mb;
            if32.cin   = c;
            if8.start  = 1'b0;
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            model_edge(0, (k == 0) && st, ma, mb, c);
            model_edge(1, (k == 1) && st, ma, mb, c);
        end
        #1;
        compare_all();
    endtask

    function automatic bit done_of(int k);
        return (k == 0) ? if8.done : if32.done;
    endfunction

    function automatic bit busy_of(int k);
        return (k == 0) ? if8.busy : if32.busy;
    endfunction

    // Start one add and run until done (bounded); lat counts edges after the accepting edge
    task automatic run_op(int k, logic [31:0] a, logic [31:0] b, bit c,
                          output int lat, output int nbusy);
        tick(k, 1'b1, a, b, c);
        lat   = 0;
        nbusy = busy_of(k) ? 1 : 0;
        while (!done_of(k) && lat < 64) begin
            tick(k, 1'b0, a, b, c);
            lat++;
            if (busy_of(k)) nbusy++;
        end
    endtask

    initial begin
        int lat, nb, last, ndone;

        rst = 1'b1;
        if8.start = 1'b0;  if8.a = '0;  if8.b = '0;  if8.cin = 1'b0;
        if32.start = 1'b0; if32.a = '0; if32.b = '0; if32.cin = 1'b0;
        model_reset();
        #12;
        chk("rst_busy8", 64'(if8.busy), 64'd0);
        chk("rst_done8", 64'(if8.done), 64'd0);
        chk("rst_sum8",  64'(if8.sum),  64'd0);
        chk("rst_cout8", 64'(if8.cout), 64'd0);
        chk("rst_sum32", 64'(if32.sum), 64'd0);
        compare_all();
        #1 rst = 1'b0;

        // Basic add
        run_op(0, 32'h5A, 32'h3C, 1'b0, lat, nb);
        chk("t1_lat",   64'(lat), 64'd8);
        chk("t1_busy",  64'(nb),  64'd8);
        chk("t1_sum",   64'(if8.sum),  64'h96);
        chk("t1_cout",  64'(if8.cout), 64'd0);

        // Carry propagation
        run_op(0, 32'hFF, 32'h01, 1'b0, lat, nb);
        chk("t2a_sum",  64'(if8.sum),  64'h00);
        chk("t2a_cout", 64'(if8.cout), 64'd1);
        run_op(0, 32'hFF, 32'h00, 1'b1, lat, nb);
        chk("t2b_sum",  64'(if8.sum),  64'h00);
        chk("t2b_cout", 64'(if8.cout), 64'd1);

        // Start held high with operands changing every cycle
        last  = -1;
        ndone = 0;
        for (int i = 0; i < 27; i++) begin
            tick(0, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
            if (if8.done) begin
                if (last >= 0) chk("t3_period", 64'(cyc - last), 64'd9);
                last = cyc;
                ndone++;
            end
        end
        chk("t3_ndone", 64'(ndone), 64'd3);
        tick(0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Reset in the middle of an add
        run_op(0, 32'hF0, 32'h01, 1'b0, lat, nb);
        tick(0, 1'b1, 32'hAA, 32'h55, 1'b0);
        for (int i = 0; i < 4; i++) tick(0, 1'b0, 32'h0, 32'h0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t4_busy", 64'(if8.busy), 64'd0);
        chk("t4_done", 64'(if8.done), 64'd0);
        chk("t4_sum",  64'(if8.sum),  64'd0);
        chk("t4_cout", 64'(if8.cout), 64'd0);
        model_reset();
        compare_all();
        #3 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick(0, 1'b0, 32'h0, 32'h0, 1'b0);
            if (if8.done) ndone++;
        end
        chk("t4_no_done", 64'(ndone), 64'd0);

        // Result hold through a later add
        run_op(0, 32'h12, 32'h34, 1'b0, lat, nb);
        chk("t5_first", 64'(if8.sum), 64'h46);
        tick(0, 1'b1, 32'hF0, 32'h0F, 1'b0);
        chk("t5_hold0", 64'(if8.sum), 64'h46);
        for (int i = 0; i < 7; i++) begin
            tick(0, 1'b0, 32'h0, 32'h0, 1'b0);
            chk("t5_hold", 64'(if8.sum), 64'h46);
        end
        tick(0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("t5_done", 64'(if8.done), 64'd1);
        chk("t5_sum",  64'(if8.sum),  64'hFF);
        chk("t5_cout", 64'(if8.cout), 64'd0);
        tick(0, 1'b0, 32'h0, 32'h0, 1'b0);

        // WIDTH=32 random adds
        for (int i = 0; i < 1000; i++) begin
            run_op(1, $urandom, $urandom, 1'($urandom_range(0, 1)), lat, nb);
            chk("t6_lat",  64'(lat), 64'd32);
            chk("t6_busy", 64'(nb),  64'd32);
        end
        chk("t6_pin_sum", 64'({if32.cout, if32.sum}), m_res[1]);
        run_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, lat, nb);
        chk("t6_max_sum",  64'(if32.sum),  64'h1);
        chk("t6_max_cout", 64'(if32.cout), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
